arcade_input_ctrl: RTL and testbench

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

---
 rtl/arcade_input_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
//   Merges PS/2 keyboard events and two MiSTer-style joystick words into
//   registered arcade control outputs, and shapes coin requests into
//   fixed-length pulses separated by a minimum low gap (up to 3 queued).
//
// Parameters
//   COIN_PULSE : coin-high length in clk_sys cycles (1 .. 2^24-1)
//   COIN_GAP   : minimum coin-low time between pulses in cycles (1 .. 2^24-1)
//
// Ports
//   clk_sys   in   system clock, all logic on its rising edge
//   reset     in   synchronous active-high reset
//   ps2_key   in   [10] event toggle, [9] pressed, [8:0] scan code (bit 8 = extended)
//   joy1/joy2 in   [0] right, [1] left, [2] down, [3] up, [4] start1, [5] start2, [6] coin
//   p1_dir    out  {up,down,left,right} for P1
//   p2_dir    out  {up,down,left,right} for P2
//   fire      out  {P2,P1}
//   start     out  {P2,P1}
//   coin      out  shaped coin pulse
//   test      out  service/test key
module arcade_input_ctrl #(
    parameter int unsigned COIN_PULSE = 2000000,
    parameter int unsigned COIN_GAP   = 2000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic [1:0]  fire,
    output logic [1:0]  start,
    output logic        coin,
    output logic        test
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPulse = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    localparam logic [23:0] PulseLoad = 24'(COIN_PULSE - 1);
    localparam logic [23:0] GapLoad   = 24'(COIN_GAP - 1);

    // Joystick bits beyond the coin bit are not used by this board.
    logic unused_joy;
    assign unused_joy = ^{joy1[15:7], joy2[15:7]};

    logic toggle_q;
    logic key_event;
    logic pressed;

    logic key_up1_q, key_down1_q, key_left1_q, key_right1_q;
    logic key_up2_q, key_down2_q, key_left2_q, key_right2_q;
    logic key_space_q, key_ctrl_q, key_fire2_q;
    logic key_f1_q, key_one_q, key_f2_q, key_two_q;
    logic key_five_q, key_six_q, key_test_q;

    logic        coin_src;
    logic        coin_src_q;
    logic        coin_req;
    logic        coin_deq;
    logic [1:0]  pending_q, pending_d;
    logic [1:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        coin_q, coin_d;

    assign key_event = ps2_key[10] ^ toggle_q;
    assign pressed   = ps2_key[9];

    // Toggle copy tracks the input even during reset so that a toggle seen
    // while in reset never turns into a key event after release.
    always_ff @(posedge clk_sys) begin
        toggle_q <= ps2_key[10];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_up1_q    <= 1'b0;
            key_down1_q  <= 1'b0;
            key_left1_q  <= 1'b0;
            key_right1_q <= 1'b0;
            key_up2_q    <= 1'b0;
            key_down2_q  <= 1'b0;
            key_left2_q  <= 1'b0;
            key_right2_q <= 1'b0;
            key_space_q  <= 1'b0;
            key_ctrl_q   <= 1'b0;
            key_fire2_q  <= 1'b0;
            key_f1_q     <= 1'b0;
            key_one_q    <= 1'b0;
            key_f2_q     <= 1'b0;
            key_two_q    <= 1'b0;
            key_five_q   <= 1'b0;
            key_six_q    <= 1'b0;
            key_test_q   <= 1'b0;
        end else if (key_event) begin
            // Arrow keys ignore the extended bit so keypad arrows also work.
            case (ps2_key[7:0])
                8'h75:   key_up1_q    <= pressed;
                8'h72:   key_down1_q  <= pressed;
                8'h6B:   key_left1_q  <= pressed;
                8'h74:   key_right1_q <= pressed;
                default: ;
            endcase
            case (ps2_key[8:0])
                9'h029:  key_space_q  <= pressed;
                9'h014:  key_ctrl_q   <= pressed;
                9'h005:  key_f1_q     <= pressed;
                9'h016:  key_one_q    <= pressed;
                9'h006:  key_f2_q     <= pressed;
                9'h01E:  key_two_q    <= pressed;
                9'h02E:  key_five_q   <= pressed;
                9'h036:  key_six_q    <= pressed;
                9'h02D:  key_up2_q    <= pressed;
                9'h02B:  key_down2_q  <= pressed;
                9'h023:  key_left2_q  <= pressed;
                9'h034:  key_right2_q <= pressed;
                9'h01C:  key_fire2_q  <= pressed;
                9'h02C:  key_test_q   <= pressed;
                default: ;
            endcase
        end
    end

    // Coin request on the rising edge of any coin source.
    assign coin_src = key_five_q | key_six_q | joy1[6] | joy2[6];
    assign coin_req = coin_src & ~coin_src_q;
    assign coin_deq = (state_q == StIdle) && (pending_q != 2'd0);

    always_comb begin
        // Request and dequeue in the same cycle cancel, even when full.
        pending_d = pending_q;
        if (coin_deq && !coin_req) begin
            pending_d = pending_q - 2'd1;
        end else if (coin_req && !coin_deq && (pending_q != 2'd3)) begin
            pending_d = pending_q + 2'd1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        case (state_q)
            StIdle: begin
                if (coin_deq) begin
                    state_d = StPulse;
                    cnt_d   = PulseLoad;
                    coin_d  = 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == 24'd0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                    coin_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            StGap: begin
                if (cnt_q == 24'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 24'd0;
                coin_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_src_q <= 1'b0;
            pending_q  <= 2'd0;
            state_q    <= StIdle;
            cnt_q      <= 24'd0;
            coin_q     <= 1'b0;
        end else begin
            coin_src_q <= coin_src;
            pending_q  <= pending_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            coin_q     <= coin_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p1_dir <= 4'd0;
            p2_dir <= 4'd0;
            fire   <= 2'd0;
            start  <= 2'd0;
            test   <= 1'b0;
        end else begin
            p1_dir <= {key_up1_q | joy1[3], key_down1_q | joy1[2],
                       key_left1_q | joy1[1], key_right1_q | joy1[0]};
            p2_dir <= {key_up2_q | joy2[3], key_down2_q | joy2[2],
                       key_left2_q | joy2[1], key_right2_q | joy2[0]};
            fire   <= {key_fire2_q, key_space_q | key_ctrl_q};
            start  <= {key_f2_q | key_two_q | joy1[5] | joy2[5],
                       key_f1_q | key_one_q | joy1[4] | joy2[4]};
            test   <= key_test_q;
        end
    end

    assign coin = coin_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
module tb_arcade_input_ctrl;

    localparam int P = 4;
    localparam int G = 3;

    // Key slots in the bench model.
    localparam int UP1 = 0, DN1 = 1, LF1 = 2, RT1 = 3;
    localparam int UP2 = 4, DN2 = 5, LF2 = 6, RT2 = 7;
    localparam int SPACE = 8, CTRL = 9, FIRE2 = 10;
    localparam int F1 = 11, ONE = 12, F2 = 13, TWO = 14;
    localparam int FIVE = 15, SIX = 16, TEST = 17;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joy1, joy2;
    logic [3:0]  p1_dir, p2_dir;
    logic [1:0]  fire, start;
    logic        coin, test;

    arcade_input_ctrl #(
        .COIN_PULSE(P),
        .COIN_GAP  (G)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .ps2_key(ps2_key),
        .joy1   (joy1),
        .joy2   (joy2),
        .p1_dir (p1_dir),
        .p2_dir (p2_dir),
        .fire   (fire),
        .start  (start),
        .coin   (coin),
        .test   (test)
    );

    always #5 clk_sys = ~clk_sys;

    // Model state
    bit  kf [0:17];
    bit  m_tog;
    bit  src_prev;
    int  pend, next_free, hi_until, n;
    logic [13:0] exp_out;

    int  vectors, miscompares;
    int  pulses, hi_cycles;
    bit  coin_prev;
    bit  tog;

    function automatic int key_idx(input logic [8:0] c);
        if (c[7:0] == 8'h75) return UP1;
        if (c[7:0] == 8'h72) return DN1;
        if (c[7:0] == 8'h6B) return LF1;
        if (c[7:0] == 8'h74) return RT1;
        case (c)
            9'h029: return SPACE;
            9'h014: return CTRL;
            9'h005: return F1;
            9'h016: return ONE;
            9'h006: return F2;
            9'h01E: return TWO;
            9'h02E: return FIVE;
            9'h036: return SIX;
            9'h02D: return UP2;
            9'h02B: return DN2;
            9'h023: return LF2;
            9'h034: return RT2;
            9'h01C: return FIRE2;
            9'h02C: return TEST;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance the model by one edge from the current inputs, clock the DUT,
    // then compare every output.
    task automatic step();
        bit src, req, deq;
        int idx;
        if (reset) begin
            for (int i = 0; i < 18; i++) kf[i] = 1'b0;
            exp_out   = '0;
            pend      = 0;
            next_free = 0;
            hi_until  = 0;
            src_prev  = 1'b0;
        end else begin
            exp_out[13:10] = {kf[UP1] | joy1[3], kf[DN1] | joy1[2],
                              kf[LF1] | joy1[1], kf[RT1] | joy1[0]};
            exp_out[9:6]   = {kf[UP2] | joy2[3], kf[DN2] | joy2[2],
                              kf[LF2] | joy2[1], kf[RT2] | joy2[0]};
            exp_out[5:4]   = {kf[FIRE2], kf[SPACE] | kf[CTRL]};
            exp_out[3:2]   = {kf[F2] | kf[TWO] | joy1[5] | joy2[5],
                              kf[F1] | kf[ONE] | joy1[4] | joy2[4]};
            exp_out[0]     = kf[TEST];
            src      = kf[FIVE] | kf[SIX] | joy1[6] | joy2[6];
            req      = src && !src_prev;
            src_prev = src;
            deq      = (pend > 0) && (n >= next_free);
            if (deq) begin
                hi_until  = n + P;
                next_free = n + P + G + 1;
            end
            pend = pend - int'(deq) + int'(req);
            if (pend > 3) pend = 3;
            if (ps2_key[10] != m_tog) begin
                idx = key_idx(ps2_key[8:0]);
                if (idx >= 0) kf[idx] = ps2_key[9];
            end
        end
        m_tog = ps2_key[10];
        exp_out[1] = !reset && (n < hi_until);
        @(posedge clk_sys);
        #1;
        check("outputs", {18'd0, p1_dir, p2_dir, fire, start, coin, test}, {18'd0, exp_out});
        if (coin === 1'b1) hi_cycles++;
        if (coin === 1'b1 && !coin_prev) pulses++;
        coin_prev = (coin === 1'b1);
        n++;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic key(input logic [8:0] code, input bit pressed);
        tog = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    logic [8:0] codes [0:10];
    int p0, h0;

    initial begin
        vectors = 0; miscompares = 0; pulses = 0; hi_cycles = 0; coin_prev = 0;
        n = 0; tog = 0; m_tog = 0;
        for (int i = 0; i < 18; i++) kf[i] = 1'b0;
        reset = 1'b1; ps2_key = '0; joy1 = '0; joy2 = '0;
        @(posedge clk_sys);
        #1;
        steps(3);
        check("reset_outputs", {18'd0, p1_dir, p2_dir, fire, start, coin, test}, 32'd0);
        reset = 1'b0;
        steps(2);

        // Arrow with and without the extended bit.
        key(9'h075, 1'b1);
        step();
        check("up1_one_edge", {28'd0, p1_dir}, 32'h0);
        step();
        check("up1_two_edges", {28'd0, p1_dir}, 32'h8);
        key(9'h175, 1'b0);
        steps(2);
        check("up1_released", {28'd0, p1_dir}, 32'h0);

        // Space and ctrl share fire1.
        key(9'h029, 1'b1); step();
        key(9'h014, 1'b1); step();
        key(9'h029, 1'b0); steps(2);
        check("fire1_ctrl_held", {30'd0, fire}, 32'h1);
        key(9'h014, 1'b0); steps(2);
        check("fire1_released", {30'd0, fire}, 32'h0);

        // Remaining mapped keys plus one unmapped code, press then release.
        codes = '{9'h005, 9'h016, 9'h006, 9'h01E, 9'h02D, 9'h02B,
                  9'h023, 9'h034, 9'h01C, 9'h02C, 9'h04A};
        for (int i = 0; i < 11; i++) begin
            key(codes[i], 1'b1); steps(2);
        end
        check("p2_dir_all", {28'd0, p2_dir}, 32'hF);
        check("start_keys", {30'd0, start}, 32'h3);
        check("test_key", {31'd0, test}, 32'h1);
        for (int i = 0; i < 11; i++) begin
            key(codes[i], 1'b0); steps(2);
        end

        // Joystick patterns.
        joy1 = 16'h0004; joy2 = 16'h0010; step();
        check("joy1_down", {28'd0, p1_dir}, 32'h4);
        check("joy2_start1", {30'd0, start}, 32'h1);
        joy1 = 16'h002B; joy2 = 16'h0005; step();
        joy1 = 16'hFF80; joy2 = 16'h0A8A; step();
        joy1 = 16'h0000; joy2 = 16'h0000; steps(2);

        // Single coin edge.
        p0 = pulses; h0 = hi_cycles;
        joy1 = 16'h0040; step();
        joy1 = 16'h0000; steps(15);
        check("single_coin_pulses", pulses - p0, 1);
        check("single_coin_high", hi_cycles - h0, P);

        // Five quick coin edges from mixed sources; the fifth is dropped.
        p0 = pulses; h0 = hi_cycles;
        joy1 = 16'h0040; step();
        joy1 = 16'h0000; step();
        joy2 = 16'h0040; step();
        joy2 = 16'h0000; key(9'h02E, 1'b1); step();
        key(9'h02E, 1'b0); step();
        key(9'h036, 1'b1); step();
        key(9'h036, 1'b0); step();
        step();
        joy1 = 16'h0040; step();
        joy1 = 16'h0000; steps(45);
        check("burst_pulses", pulses - p0, 4);
        check("burst_high", hi_cycles - h0, 4 * P);

        // Held coin source yields one pulse.
        p0 = pulses;
        joy2 = 16'h0040; steps(50);
        joy2 = 16'h0000; steps(5);
        check("held_coin_pulses", pulses - p0, 1);

        // Reset mid-pulse with two pending; key toggle during reset.
        for (int i = 0; i < 4; i++) begin
            joy1 = 16'h0040; step();
            joy1 = 16'h0000; step();
        end
        step();
        step();
        check("second_pulse_high", {31'd0, coin}, 32'h1);
        reset = 1'b1;
        key(9'h075, 1'b1);
        step();
        check("coin_dropped_by_reset", {31'd0, coin}, 32'h0);
        steps(2);
        reset = 1'b0;
        p0 = pulses;
        steps(30);
        check("no_pulses_after_reset", pulses - p0, 0);
        check("no_key_after_reset", {28'd0, p1_dir}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
